// File: rtl/wb_regfile_pkg.sv
// Shared types and constants for the write-back register file: bus widths,
// zero/NOP values, enable levels and the active-low reset level.
package wb_regfile_pkg;

    localparam int RegWidth  = 32;
    localparam int AddrWidth = 5;

    typedef logic [RegWidth-1:0]  RegBus;
    typedef logic [AddrWidth-1:0] RegAddrBus;

    localparam RegBus     ZeroWord   = '0;
    localparam RegAddrBus NOPRegAddr = '0;

    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;
    localparam logic ReadEnable   = 1'b1;
    localparam logic ReadDisable  = 1'b0;

    // Reset is asserted when the reset pin is low.
    localparam logic RstEnable  = 1'b0;
    localparam logic RstDisable = 1'b1;

endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB write-back requests, decode read ports and debug readout of the
// register file, bundled as one interface.
interface wb_regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] wb_wd;
    logic              wb_wreg;
    logic [DATA_W-1:0] wb_wdata;
    logic [DATA_W-1:0] wb_hi;
    logic [DATA_W-1:0] wb_lo;
    logic              wb_whilo;

    logic              re1;
    logic [ADDR_W-1:0] raddr1;
    logic [DATA_W-1:0] rdata1;
    logic              re2;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata2;

    logic [DATA_W-1:0] hi_o;
    logic [DATA_W-1:0] lo_o;
    logic [31:0]       commit_cnt;

    modport master (
        output wb_wd, wb_wreg, wb_wdata, wb_hi, wb_lo, wb_whilo,
        output re1, raddr1, re2, raddr2,
        input  rdata1, rdata2, hi_o, lo_o, commit_cnt
    );

    modport slave (
        input  wb_wd, wb_wreg, wb_wdata, wb_hi, wb_lo, wb_whilo,
        input  re1, raddr1, re2, raddr2,
        output rdata1, rdata2, hi_o, lo_o, commit_cnt
    );

endinterface

// File: rtl/wb_regfile_hilo_reg.sv
// HI/LO register pair: written together, with a same-cycle bypass of the
// incoming write-back values onto the outputs.
module hilo_reg
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [DATA_W-1:0] hi_wdata,
    input  logic [DATA_W-1:0] lo_wdata,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (we == WriteEnable) begin
            hi_q <= hi_wdata;
            lo_q <= lo_wdata;
        end
    end

    // Outputs are forced to zero during reset even if a write is being presented.
    always_comb begin
        hi = '0;
        lo = '0;
        if (rst == RstDisable) begin
            if (we == WriteEnable) begin
                hi = hi_wdata;
                lo = lo_wdata;
            end else begin
                hi = hi_q;
                lo = lo_q;
            end
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// Write-back register file: 2^ADDR_W GPRs with r0 hardwired to zero, two
// bypassed read ports, the HI/LO pair and a commit counter.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic         clk,
    input  logic         rst,
    wb_regfile_if.slave  bus
);

    localparam int NumRegs = 2 ** ADDR_W;

    logic [DATA_W-1:0] gpr [NumRegs];
    logic [31:0]       commit_q;
    logic              gpr_write;
    logic              commit;

    assign gpr_write = (bus.wb_wreg == WriteEnable) && (bus.wb_wd != '0);
    assign commit    = gpr_write || (bus.wb_whilo == WriteEnable);

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            for (int i = 0; i < NumRegs; i++) begin
                gpr[i] <= '0;
            end
        end else if (gpr_write) begin
            gpr[bus.wb_wd] <= bus.wb_wdata;
        end
    end

    // Counts cycles, not writes: a GPR and HI/LO write in one cycle add one.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            commit_q <= '0;
        end else if (commit) begin
            commit_q <= commit_q + 32'd1;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic re, input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] data;
        data = '0;
        if (rst == RstEnable || re == ReadDisable || addr == '0) begin
            data = '0;
        end else if (bus.wb_wreg == WriteEnable && addr == bus.wb_wd) begin
            data = bus.wb_wdata;
        end else begin
            data = gpr[addr];
        end
        return data;
    endfunction

    always_comb begin
        bus.rdata1 = read_port(bus.re1, bus.raddr1);
        bus.rdata2 = read_port(bus.re2, bus.raddr2);
    end

    assign bus.commit_cnt = commit_q;

    hilo_reg #(
        .DATA_W (DATA_W)
    ) u_hilo (
        .clk      (clk),
        .rst      (rst),
        .we       (bus.wb_whilo),
        .hi_wdata (bus.wb_hi),
        .lo_wdata (bus.wb_lo),
        .hi       (bus.hi_o),
        .lo       (bus.lo_o)
    );

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back consumer of the MEM/WB pipeline register: a 32×32 general-purpose register file plus the HI/LO register pair, committing the `wb_*` write requests at the clock edge. It serves two decode-stage read ports and one HI/LO read port, each with same-cycle write-back bypass. It also keeps a 32-bit commit counter for debug/performance readout. It sits at the end of the pipeline, consuming `wb_wd/wb_wreg/wb_wdata` and `wb_hi/wb_lo/wb_whilo`.

## Interface
Parameters:
- `DATA_W`, 32, width of GPRs, HI, LO and read data
- `ADDR_W`, 5, register address width (2^ADDR_W registers)

Ports:
- `clk`  in  1  system clock, rising-edge active
- `rst`  in  1  reset; asynchronous, active-low
- `wb_wd`  in  ADDR_W  GPR write address
- `wb_wreg`  in  1  GPR write enable
- `wb_wdata`  in  DATA_W  GPR write data
- `wb_hi`  in  DATA_W  HI write data
- `wb_lo`  in  DATA_W  LO write data
- `wb_whilo`  in  1  HI/LO write enable (writes both)
- `re1`  in  1  read port 1 enable
- `raddr1`  in  ADDR_W  read port 1 address
- `rdata1`  out  DATA_W  read port 1 data, combinational
- `re2`  in  1  read port 2 enable
- `raddr2`  in  ADDR_W  read port 2 address
- `rdata2`  out  DATA_W  read port 2 data, combinational
- `hi_o`  out  DATA_W  current HI, bypassed
- `lo_o`  out  DATA_W  current LO, bypassed
- `commit_cnt`  out  32  count of cycles with at least one architectural write committed

## Operation
- GPR write: at posedge `clk`, if `rst` is high, `wb_wreg`=1 and `wb_wd`≠0, then `gpr[wb_wd]` ← `wb_wdata`. A write to register 0 is discarded; register 0 always reads 0.
- HI/LO write: at posedge, if `wb_whilo`=1, then HI ← `wb_hi` and LO ← `wb_lo`. Both registers are written together, never individually.
- Read port n (n=1,2), priority order:
  1. `re`n=0 → 0.
  2. `raddr`n=0 → 0.
  3. `wb_wreg`=1 and `raddr`n=`wb_wd` → `wb_wdata` (bypass).
  4. Otherwise → `gpr[raddr`n`]`.
- Both ports may address the same register in the same cycle; each resolves independently.
- `hi_o`/`lo_o` = `wb_hi`/`wb_lo` when `wb_whilo`=1, otherwise the stored HI/LO.
- `commit_cnt` increments by 1 at posedge when (`wb_wreg`=1 and `wb_wd`≠0) or `wb_whilo`=1.
  - Simultaneous GPR and HI/LO writes count once.
  - Wraps from 0xFFFF_FFFF to 0 with no flag.
- No state machine: all state is storage plus the counter.

## Timing
- Reset (`rst`=0, asynchronous) forces, immediately and independent of `clk`:
  - all GPRs, HI and LO to 0;
  - `commit_cnt` to 0;
  - `rdata1`, `rdata2`, `hi_o` and `lo_o` to 0.
  - Write inputs are ignored for as long as `rst` is low.
- Reset asserted mid-operation discards any write pending at the next edge. The first write is accepted at the first posedge after `rst` rises.
- Write latency is one edge: data presented in cycle N is visible from storage in cycle N+1. Through the bypass path, it is also visible combinationally in cycle N.
- Read paths are purely combinational from `raddr`/`re`/`wb_*` to `rdata`; there is no registered output.
- `wb_*` inputs come directly from the MEM/WB register outputs. No additional input flopping is allowed: it would break the single-cycle bypass.

## Structure
- Shared package/define file: `RegBus`, `RegAddrBus`, `ZeroWord`, `NOPRegAddr`, `WriteEnable`/`WriteDisable`, `ReadEnable`/`ReadDisable`, and the active-low reset level constant.
- One natural sub-module, `hilo_reg`: it holds HI/LO with async reset and the write/bypass mux. The GPR array and the counter stay in `wb_regfile`.

## Test plan
- Reset: hold `rst`=0 and write attempts `wb_wd`=5, `wb_wdata`=0xDEAD_BEEF → `rdata1`/`rdata2`/`hi_o`/`lo_o`=0 and `commit_cnt`=0; after release, reading r5 returns 0.
- Write then read: write r7=0x1234_5678 at edge N, then in cycle N+1 set `re1`=1, `raddr1`=7 → `rdata1`=0x1234_5678.
- Bypass and r0: in the same cycle set `wb_wreg`=1, `wb_wd`=3, `wb_wdata`=0xA5A5_A5A5, `raddr1`=3, `raddr2`=0 (both enabled) → `rdata1`=0xA5A5_A5A5, `rdata2`=0. Next, write r0=0xFFFF_FFFF → r0 still reads 0 and `commit_cnt` is unchanged.
- HI/LO: `wb_whilo`=1, `wb_hi`=0x1, `wb_lo`=0x2 → `hi_o`/`lo_o` = 1/2 in the same cycle and after the edge. Then drive `wb_whilo`=0 with `wb_hi`=0x9 → `hi_o` stays 1.
- Counter: 3 cycles of GPR-only writes, 1 cycle with both GPR and HI/LO writes, 2 idle cycles → `commit_cnt`=4. Preload near 0xFFFF_FFFF via repeated writes (or force) → wraps to 0.
- Async reset mid-stream: drop `rst` between edges while `wb_wreg`=1 → outputs go to 0 before the next edge and the pending write is lost.
